mem_axi_lsu: RTL and testbench
==============================

# mem_axi_lsu

Load/store unit of the MEM stage: turns the MEM-stage memory request into single AXI4-Lite read or write transactions on the data bus. While a transaction is in flight it holds `stall_req`, which drives `stall_en` of every pipeline buffer. It returns the aligned, sign- or zero-extended load word in a one-cycle `rsp_valid` slot, and the MEM-to-WB buffer captures that word on the same edge.

## Interface
- `ADDR_W`, default 32: address width; data is fixed at 32 bits.
- `ACLK`  in  1: clock; everything is rising-edge.
- `ARESET`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: MEM stage holds a load or store.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 = byte, 01 = half, 10 or 11 = word.
- `req_unsigned`  in  1: zero-extend the load (LBU/LHU).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `stall_req`  out  1: freeze the pipeline buffers.
- `rsp_valid`  out  1: single-cycle pulse, access complete.
- `rsp_rdata`  out  32: extended load data; 0 for stores.
- `fault`  out  1: misaligned access; valid with `rsp_valid`.
- AW channel: `M_AWADDR` out ADDR_W, `M_AWVALID` out 1, `M_AWREADY` in 1.
- W channel: `M_WDATA` out 32, `M_WSTRB` out 4, `M_WVALID` out 1, `M_WREADY` in 1.
- B channel: `M_BRESP` in 2, `M_BVALID` in 1, `M_BREADY` out 1.
- AR channel: `M_ARADDR` out ADDR_W, `M_ARVALID` out 1, `M_ARREADY` in 1.
- R channel: `M_RDATA` in 32, `M_RRESP` in 2, `M_RVALID` in 1, `M_RREADY` out 1.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Request capture:
  - In IDLE with `req_valid`=1, latch we/size/unsigned/addr/wdata.
  - Next state is RD_ADDR for a load, WR_REQ for a store.
  - `req_*` is ignored in every other state.
- Stall: `stall_req` = (state==IDLE && req_valid) || state ∈ {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}. This is combinational from `req_valid` in IDLE.
- RD_ADDR:
  - `M_ARVALID`=1 with `M_ARADDR`={addr[ADDR_W-1:2],2'b00}.
  - On `M_ARREADY`, go to RD_DATA.
- RD_DATA:
  - `M_RREADY`=1.
  - On `M_RVALID`, register the extracted data and go to DONE.
- Load extraction:
  - Shift `M_RDATA` right by 8·addr[1:0].
  - Byte uses bits [7:0]; half uses bits [15:0]; word uses all 32 bits.
  - Sign-extend unless `req_unsigned`=1.
- WR_REQ, AW and W channels:
  - `M_AWVALID` and `M_WVALID` both assert on entry.
  - Each deasserts independently after its own handshake; track each with an internal done flag.
  - When both have handshaken, go to WR_RESP.
- Store lanes:
  - Byte: WSTRB = 1<<addr[1:0]; WDATA = wdata[7:0] replicated ×4.
  - Half: WSTRB = 4'b0011<<(2·addr[1]); WDATA = wdata[15:0] replicated ×2.
  - Word: WSTRB = 4'hF; WDATA = wdata.
- WR_RESP: `M_BREADY`=1; on `M_BVALID`, go to DONE.
- DONE:
  - `rsp_valid`=1 and `stall_req`=0, so the pipeline advances on this edge.
  - Always return to IDLE.
  - A `req_valid` seen in DONE belongs to the same instruction and is ignored.
- RRESP/BRESP: non-OKAY responses are ignored; data is still returned.
- All AXI VALID/READY outputs are registered state decodes. No VALID output drops before its handshake.

## Timing
- Reset: state=IDLE.
- Values while reset is held: all M_*VALID/READY=0, `rsp_valid`=0, `rsp_rdata`=0, `fault`=0, `stall_req`=0.
- Address/data outputs after reset: 0.
- Zero-wait-state load:
  - Stall for 3 cycles (IDLE, RD_ADDR, RD_DATA).
  - `rsp_valid` asserts in cycle 3.
- Zero-wait-state store:
  - Stall for 3 cycles (IDLE, WR_REQ, WR_RESP), with BVALID arriving in the WR_RESP cycle.
  - `rsp_valid` asserts in cycle 3.
- Each slave wait cycle on AR/R/AW/W/B adds exactly one stall cycle. AW and W may complete in different cycles, in either order.
- Back-to-back requests: minimum spacing is 4 cycles, because DONE always precedes the next IDLE accept.
- `rsp_rdata` stays stable from DONE until the next DONE.
- Reset asserted mid-transaction: the FSM returns to IDLE asynchronously and the in-flight transaction is abandoned. The slave is reset by the same system reset.

## Configuration
- Macro: `MISALIGN_CHECK_EN`.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, goes IDLE→DONE with no AXI activity.
  - In that DONE cycle: `fault`=1, `rsp_rdata`=0; `stall_req` was high for the IDLE cycle only.
- Undefined:
  - No check is made; `fault` is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan
- LW at 0x100, slave returns RDATA=0xDEADBEEF with zero wait states: ARADDR=0x100, stall for 3 cycles, `rsp_valid` in cycle 3 with `rsp_rdata`=0xDEADBEEF.
- LB at 0x103, then LBU at 0x103, RDATA=0x80FF1234 both times: the LB returns `rsp_rdata`=0xFFFFFF80 and the LBU returns 0x00000080.
- SH at 0x102 with wdata=0x0000ABCD, WREADY delayed 2 cycles after AWREADY: WSTRB=4'b1100, WDATA=0xABCDABCD, AWVALID drops first, BREADY only after W completes.
- RVALID withheld for 5 cycles: `stall_req` stays high throughout, then `rsp_valid` pulses exactly one cycle.
- ARESET pulsed while in RD_DATA: ARVALID/RREADY/`stall_req` go to 0 immediately; a new LW afterwards completes normally.
- With `MISALIGN_CHECK_EN`, LW at 0x101: no ARVALID, `fault`=1 and `rsp_valid`=1 in cycle 1. Without the macro: ARADDR=0x100 and a normal load.

Source files
------------

// File: rtl/mem_axi_lsu_if.sv
// AXI4-Lite data-bus bundle between the MEM-stage load/store unit (master) and memory (slave).
interface mem_axi_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] M_AWADDR;
    logic              M_AWVALID;
    logic              M_AWREADY;
    logic [31:0]       M_WDATA;
    logic [3:0]        M_WSTRB;
    logic              M_WVALID;
    logic              M_WREADY;
    logic [1:0]        M_BRESP;
    logic              M_BVALID;
    logic              M_BREADY;
    logic [ADDR_W-1:0] M_ARADDR;
    logic              M_ARVALID;
    logic              M_ARREADY;
    logic [31:0]       M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RVALID;
    logic              M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
               M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY,
               M_RDATA, M_RRESP, M_RVALID
    );
endinterface

// File: rtl/mem_axi_lsu.sv
// MEM-stage load/store unit: one AXI4-Lite read or write per request, pipeline stall while in flight.
// Optional MISALIGN_CHECK_EN: misaligned half/word accesses fault without touching the bus.
module mem_axi_lsu #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_req,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    mem_axi_lsu_if.master     m_axi
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;
    logic              r_aw_done, r_w_done;
    logic              w_capture, w_misalign, w_aw_hs, w_w_hs, w_wr_both;
    logic [1:0]        w_ld_off;
    logic [31:0]       w_ld_shift, w_ld_data, w_st_data;
    logic [3:0]        w_st_strb;
    logic              w_unused_resp;

    // Byte offset actually honoured: half ignores addr[0], word ignores addr[1:0].
    function automatic logic [1:0] f_offset(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return lo;
            2'b01:   return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    assign w_capture     = (r_state == IDLE) && req_valid;
    assign w_aw_hs       = m_axi.M_AWVALID && m_axi.M_AWREADY;
    assign w_w_hs        = m_axi.M_WVALID && m_axi.M_WREADY;
    assign w_wr_both     = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_unused_resp = ^{m_axi.M_RRESP, m_axi.M_BRESP};

`ifdef MISALIGN_CHECK_EN
    logic r_fault;
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    // Fault is visible only in the DONE cycle that follows the rejected request.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_fault <= 1'b0;
        else        r_fault <= w_capture && w_misalign;
    end
    assign fault = r_fault;
`else
    assign w_misalign = 1'b0;
    assign fault      = 1'b0;
`endif

    // Store lane placement, computed from the live request so it can be latched.
    always_comb begin
        case (req_size)
            2'b00: begin
                w_st_strb = 4'b0001 << req_addr[1:0];
                w_st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << {req_addr[1], 1'b0};
                w_st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_strb = 4'hF;
                w_st_data = req_wdata;
            end
        endcase
    end

    // Load alignment and extension from the latched request.
    always_comb begin
        w_ld_off   = f_offset(r_size, r_addr[1:0]);
        w_ld_shift = m_axi.M_RDATA >> {w_ld_off, 3'b000};
        case (r_size)
            2'b00:   w_ld_data = r_unsigned ? {24'h0, w_ld_shift[7:0]}
                                            : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'b01:   w_ld_data = r_unsigned ? {16'h0, w_ld_shift[15:0]}
                                            : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stall_req = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                stall_req = req_valid && !ARESET;
                if (req_valid) begin
                    if (w_misalign)  w_next = DONE;
                    else if (req_we) w_next = WR_REQ;
                    else             w_next = RD_ADDR;
                end
            end
            RD_ADDR: begin
                stall_req = 1'b1;
                if (m_axi.M_ARREADY) w_next = RD_DATA;
            end
            RD_DATA: begin
                stall_req = 1'b1;
                if (m_axi.M_RVALID) w_next = DONE;
            end
            WR_REQ: begin
                stall_req = 1'b1;
                if (w_wr_both) w_next = WR_RESP;
            end
            WR_RESP: begin
                stall_req = 1'b1;
                if (m_axi.M_BVALID) w_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, AW/W completion flags and the held response word.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'h0;
            r_rdata    <= 32'h0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= w_st_data;
                r_wstrb    <= w_st_strb;
            end
            r_aw_done <= (r_state == WR_REQ) && (r_aw_done || w_aw_hs);
            r_w_done  <= (r_state == WR_REQ) && (r_w_done || w_w_hs);
            if ((r_state == RD_DATA) && m_axi.M_RVALID)
                r_rdata <= w_ld_data;
            else if ((r_state == WR_RESP) && m_axi.M_BVALID)
                r_rdata <= 32'h0;
            else if (w_capture && w_misalign)
                r_rdata <= 32'h0;
        end
    end

    assign rsp_rdata       = r_rdata;
    assign m_axi.M_ARADDR  = {r_addr[ADDR_W-1:2], 2'b00};
    assign m_axi.M_AWADDR  = {r_addr[ADDR_W-1:2], 2'b00};
    assign m_axi.M_WDATA   = r_wdata;
    assign m_axi.M_WSTRB   = r_wstrb;
    assign m_axi.M_ARVALID = (r_state == RD_ADDR);
    assign m_axi.M_RREADY  = (r_state == RD_DATA);
    assign m_axi.M_AWVALID = (r_state == WR_REQ) && !r_aw_done;
    assign m_axi.M_WVALID  = (r_state == WR_REQ) && !r_w_done;
    assign m_axi.M_BREADY  = (r_state == WR_RESP);
endmodule

// File: tb/tb_mem_axi_lsu.sv
// Directed bench for mem_axi_lsu: loads, stores, wait states, reset abort, back-to-back, misalignment.
module tb_mem_axi_lsu;
    localparam int unsigned ADDR_W = 32;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              req_valid, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall_req, rsp_valid, fault;
    logic [31:0]       rsp_rdata;
    int                checks   = 0;
    int                failures = 0;

    mem_axi_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    mem_axi_lsu #(.ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_req(stall_req), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .fault(fault), .m_axi(bus)
    );

    always #5 ACLK = ~ACLK;

    // Load driver: slave accepts AR at once, holds RVALID off for r_wait RREADY cycles.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input int r_wait,
                           output int stalls, output int rc, output logic [31:0] data,
                           output logic [31:0] araddr, output logic ar_seen, output logic flt);
        int rcnt = 0;
        stalls = 0; rc = -1; data = 32'h0; araddr = 32'h0; ar_seen = 1'b0; flt = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = 32'h0;
        bus.M_ARREADY = 1'b1; bus.M_RDATA = rdata; bus.M_RVALID = 1'b0;
        for (int c = 0; c < 40 && rc < 0; c++) begin
            #1;
            if (stall_req) stalls++;
            if (bus.M_ARVALID) begin ar_seen = 1'b1; araddr = bus.M_ARADDR; end
            if (rsp_valid) begin rc = c; data = rsp_rdata; flt = fault; end
            if (bus.M_RREADY) begin bus.M_RVALID = (rcnt >= r_wait); rcnt++; end
            else bus.M_RVALID = 1'b0;
            @(negedge ACLK);
        end
        req_valid = 1'b0; bus.M_RVALID = 1'b0; bus.M_ARREADY = 1'b0;
    endtask

    // Store driver: AWREADY/WREADY held off for aw_wait/w_wait valid cycles, BVALID immediate.
    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                            input int aw_wait, input int w_wait,
                            output int stalls, output int rc, output logic [31:0] data,
                            output logic [31:0] awaddr, output logic [3:0] wstrb,
                            output logic [31:0] wdat, output int aw_last, output int w_last,
                            output int b_first);
        int awcnt = 0;
        int wcnt  = 0;
        stalls = 0; rc = -1; data = 32'hFFFF_FFFF; awaddr = 32'h0; wstrb = 4'h0; wdat = 32'h0;
        aw_last = -1; w_last = -1; b_first = -1;
        req_valid = 1'b1; req_we = 1'b1; req_size = size; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 40 && rc < 0; c++) begin
            #1;
            if (stall_req) stalls++;
            if (rsp_valid) begin rc = c; data = rsp_rdata; end
            if (bus.M_AWVALID) begin
                awaddr = bus.M_AWADDR; aw_last = c;
                bus.M_AWREADY = (awcnt >= aw_wait); awcnt++;
            end else bus.M_AWREADY = 1'b0;
            if (bus.M_WVALID) begin
                wstrb = bus.M_WSTRB; wdat = bus.M_WDATA; w_last = c;
                bus.M_WREADY = (wcnt >= w_wait); wcnt++;
            end else bus.M_WREADY = 1'b0;
            if (bus.M_BREADY) begin
                if (b_first < 0) b_first = c;
                bus.M_BVALID = 1'b1;
            end else bus.M_BVALID = 1'b0;
            @(negedge ACLK);
        end
        req_valid = 1'b0; req_we = 1'b0;
        bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
        bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00;
        bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = 32'h0; bus.M_RRESP = 2'b00;
        repeat (2) @(negedge ACLK);
        #1;
        checks++;
        if ({bus.M_ARVALID, bus.M_RREADY, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY} !== 5'b0) begin
            failures++; $display("FAIL reset_handshakes got=%b exp=00000",
                {bus.M_ARVALID, bus.M_RREADY, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY});
        end
        checks++;
        if ({stall_req, rsp_valid, fault} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000", {stall_req, rsp_valid, fault});
        end
        checks++;
        if ({rsp_rdata, bus.M_ARADDR, bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB} !== 132'h0) begin
            failures++; $display("FAIL reset_data got rdata=%h ar=%h aw=%h wd=%h ws=%h exp=0",
                rsp_rdata, bus.M_ARADDR, bus.M_AWADDR, bus.M_WDATA, bus.M_WSTRB);
        end
        req_valid = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_load_word();
        int st, rc; logic [31:0] d, a; logic ars, f;
        do_load(32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 0, st, rc, d, a, ars, f);
        checks++; if (a !== 32'h100) begin failures++; $display("FAIL lw_araddr got=%h exp=00000100", a); end
        checks++; if (st !== 3) begin failures++; $display("FAIL lw_stall got=%0d exp=3", st); end
        checks++; if (rc !== 3) begin failures++; $display("FAIL lw_rsp_cycle got=%0d exp=3", rc); end
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", d); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL lw_fault got=%b exp=0", f); end
    endtask

    task automatic test_load_sub();
        int st, rc; logic [31:0] d, a; logic ars, f;
        do_load(32'h103, 2'b00, 1'b0, 32'h80FF1234, 0, st, rc, d, a, ars, f);
        checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", d); end
        checks++; if (a !== 32'h100) begin failures++; $display("FAIL lb_araddr got=%h exp=00000100", a); end
        do_load(32'h103, 2'b00, 1'b1, 32'h80FF1234, 0, st, rc, d, a, ars, f);
        checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", d); end
        do_load(32'h102, 2'b01, 1'b0, 32'h80FF1234, 0, st, rc, d, a, ars, f);
        checks++; if (d !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ff", d); end
        do_load(32'h100, 2'b01, 1'b1, 32'h80FF9234, 0, st, rc, d, a, ars, f);
        checks++; if (d !== 32'h00009234) begin failures++; $display("FAIL lhu_data got=%h exp=00009234", d); end
    endtask

    task automatic test_store();
        int st, rc, al, wl, bf; logic [31:0] d, aw, wd; logic [3:0] ws;
        do_store(32'h200, 2'b10, 32'h11223344, 0, 0, st, rc, d, aw, ws, wd, al, wl, bf);
        checks++; if (st !== 3 || rc !== 3) begin failures++; $display("FAIL sw_timing got stall=%0d rsp=%0d exp=3/3", st, rc); end
        checks++; if (ws !== 4'hF || wd !== 32'h11223344) begin failures++; $display("FAIL sw_lanes got=%h/%h exp=f/11223344", ws, wd); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=00000000", d); end
        do_store(32'h201, 2'b00, 32'h000000A5, 0, 0, st, rc, d, aw, ws, wd, al, wl, bf);
        checks++; if (ws !== 4'b0010 || wd !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_lanes got=%h/%h exp=2/a5a5a5a5", ws, wd); end
        checks++; if (aw !== 32'h200) begin failures++; $display("FAIL sb_awaddr got=%h exp=00000200", aw); end
    endtask

    task automatic test_store_w_late();
        int st, rc, al, wl, bf; logic [31:0] d, aw, wd; logic [3:0] ws;
        do_store(32'h102, 2'b01, 32'h0000ABCD, 0, 2, st, rc, d, aw, ws, wd, al, wl, bf);
        checks++; if (ws !== 4'b1100 || wd !== 32'hABCDABCD) begin failures++; $display("FAIL sh_lanes got=%h/%h exp=c/abcdabcd", ws, wd); end
        checks++; if (al !== 1 || wl !== 3) begin failures++; $display("FAIL sh_order got aw_last=%0d w_last=%0d exp=1/3", al, wl); end
        checks++; if (bf !== 4) begin failures++; $display("FAIL sh_bready got=%0d exp=4", bf); end
        checks++; if (st !== 5 || rc !== 5) begin failures++; $display("FAIL sh_timing got stall=%0d rsp=%0d exp=5/5", st, rc); end
        do_store(32'h204, 2'b10, 32'h55667788, 2, 0, st, rc, d, aw, ws, wd, al, wl, bf);
        checks++; if (al !== 3 || wl !== 1 || bf !== 4 || rc !== 5) begin failures++;
            $display("FAIL sw_aw_late got aw=%0d w=%0d b=%0d rsp=%0d exp=3/1/4/5", al, wl, bf, rc); end
    endtask

    task automatic test_rvalid_wait();
        int st, rc; logic [31:0] d, a; logic ars, f;
        do_load(32'h104, 2'b10, 1'b0, 32'h00007FFF, 5, st, rc, d, a, ars, f);
        checks++; if (st !== 8 || rc !== 8) begin failures++; $display("FAIL rwait_timing got stall=%0d rsp=%0d exp=8/8", st, rc); end
        checks++; if (d !== 32'h00007FFF) begin failures++; $display("FAIL rwait_data got=%h exp=00007fff", d); end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rwait_pulse got=%b exp=0", rsp_valid); end
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid();
        int st, rc; logic [31:0] d, a; logic ars, f;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h300;
        bus.M_ARREADY = 1'b1; bus.M_RVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        checks++; if (bus.M_RREADY !== 1'b1) begin failures++; $display("FAIL rst_mid_setup got=%b exp=1", bus.M_RREADY); end
        #2 ARESET = 1'b1;
        #1;
        checks++; if ({bus.M_ARVALID, bus.M_RREADY, stall_req} !== 3'b000) begin failures++;
            $display("FAIL rst_mid_abort got=%b exp=000", {bus.M_ARVALID, bus.M_RREADY, stall_req}); end
        req_valid = 1'b0; bus.M_ARREADY = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        do_load(32'h100, 2'b10, 1'b0, 32'h0BADF00D, 0, st, rc, d, a, ars, f);
        checks++; if (d !== 32'h0BADF00D || rc !== 3) begin failures++; $display("FAIL rst_mid_after got=%h/%0d exp=0badf00d/3", d, rc); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, pulses = 0;
        logic stable = 1'b1;
        logic [31:0] d2 = 32'h0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100;
        bus.M_ARREADY = 1'b1; bus.M_RDATA = 32'h11111111; bus.M_RVALID = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rsp_valid) begin
                pulses++;
                if (first < 0) begin first = c; req_addr = 32'h104; bus.M_RDATA = 32'h22222222; end
                else if (second < 0) begin second = c; d2 = rsp_rdata; req_valid = 1'b0; end
            end else if (first >= 0 && second < 0 && rsp_rdata !== 32'h11111111) stable = 1'b0;
            bus.M_RVALID = bus.M_RREADY;
            @(negedge ACLK);
        end
        bus.M_RVALID = 1'b0; bus.M_ARREADY = 1'b0;
        checks++; if (first !== 3 || second !== 7) begin failures++; $display("FAIL b2b_spacing got=%0d/%0d exp=3/7", first, second); end
        checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (d2 !== 32'h22222222) begin failures++; $display("FAIL b2b_data got=%h exp=22222222", d2); end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%b exp=1", stable); end
    endtask

    task automatic test_misalign();
        int st, rc; logic [31:0] d, a; logic ars, f;
        do_load(32'h101, 2'b10, 1'b0, 32'hCAFEF00D, 0, st, rc, d, a, ars, f);
`ifdef MISALIGN_CHECK_EN
        checks++; if (ars !== 1'b0) begin failures++; $display("FAIL mis_no_ar got=%b exp=0", ars); end
        checks++; if (rc !== 1 || st !== 1) begin failures++; $display("FAIL mis_timing got rsp=%0d stall=%0d exp=1/1", rc, st); end
        checks++; if (f !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL mis_fault got=%b/%h exp=1/00000000", f, d); end
        #1;
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_fault_clear got=%b exp=0", fault); end
        @(negedge ACLK);
`else
        checks++; if (a !== 32'h100) begin failures++; $display("FAIL mis_araddr got=%h exp=00000100", a); end
        checks++; if (rc !== 3 || d !== 32'hCAFEF00D) begin failures++; $display("FAIL mis_load got=%0d/%h exp=3/cafef00d", rc, d); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL mis_fault got=%b exp=0", f); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_store_w_late();
        test_rvalid_wait();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
